lfsr_spawn_gen: RTL and testbench

- Parametrised pseudo-random position generator for the Breakout playfield.
- Successor to the fixed-width free-running LFSR x/y block.
- Adds configurable LFSR width and taps, runtime seeding, and bounded x/y ranges enforced by rejection sampling with a deterministic fallback.
- Adds a valid/ready request handshake, so ball/brick/power-up spawn logic can ask for a fresh in-bounds location on demand.

---
 rtl/lfsr_spawn_gen_if.sv | 23 ++
 rtl/lfsr_spawn_gen.sv | 138 +++++++++++++
 tb/tb_lfsr_spawn_gen.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_spawn_gen_if.sv
// Request/response bundle between spawn logic (master) and the position generator (slave).
interface lfsr_spawn_gen_if #(
  parameter int unsigned X_W = 11,
  parameter int unsigned Y_W = 10
);
  logic           req;
  logic           busy;
  logic           loc_valid;
  logic           loc_ready;
  logic [X_W-1:0] x_loc;
  logic [Y_W-1:0] y_loc;
  logic           fallback;

  modport master (
    output req, loc_ready,
    input  busy, loc_valid, x_loc, y_loc, fallback
  );

  modport slave (
    input  req, loc_ready,
    output busy, loc_valid, x_loc, y_loc, fallback
  );
endinterface

// File: rtl/lfsr_spawn_gen.sv
// Galois-LFSR driven spawn position generator: bounded x/y via rejection sampling with a
// midpoint fallback after MAX_TRIES misses, delivered over a valid/ready handshake.
module lfsr_spawn_gen #(
  parameter int unsigned          LFSR_W    = 16,
  parameter logic [LFSR_W-1:0]    TAPS      = 16'hB400,
  parameter logic [LFSR_W-1:0]    SEED      = 16'hACE1,
  parameter int unsigned          X_W       = 11,
  parameter int unsigned          Y_W       = 10,
  parameter int unsigned          X_MIN     = 16,
  parameter int unsigned          X_MAX     = 1263,
  parameter int unsigned          Y_MIN     = 16,
  parameter int unsigned          Y_MAX     = 511,
  parameter int unsigned          MAX_TRIES = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              seed_load_i,
  input  logic [LFSR_W-1:0] seed_in_i,
  lfsr_spawn_gen_if.slave   bus
);

  if ((X_MAX >> X_W) != 0 || (Y_MAX >> Y_W) != 0 || X_MIN > X_MAX || Y_MIN > Y_MAX ||
      LFSR_W < X_W || LFSR_W < Y_W || MAX_TRIES < 1) begin : g_param_check
    $error("lfsr_spawn_gen: illegal coordinate range or width parameters");
  end

  localparam int unsigned    TriesW    = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TriesW-1:0] TriesLast = TriesW'(MAX_TRIES - 1);
  localparam logic [X_W-1:0] XLo  = X_W'(X_MIN);
  localparam logic [X_W-1:0] XHi  = X_W'(X_MAX);
  localparam logic [X_W-1:0] XMid = X_W'(X_MIN + ((X_MAX - X_MIN) >> 1));
  localparam logic [Y_W-1:0] YLo  = Y_W'(Y_MIN);
  localparam logic [Y_W-1:0] YHi  = Y_W'(Y_MAX);
  localparam logic [Y_W-1:0] YMid = Y_W'(Y_MIN + ((Y_MAX - Y_MIN) >> 1));

  typedef enum logic [1:0] {StIdle, StDrawX, StDrawY, StDone} state_e;

  state_e              state_q, state_d;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d, lfsr_step;
  logic [TriesW-1:0]   tries_q, tries_d;
  logic [X_W-1:0]      x_q, x_d, cx;
  logic [Y_W-1:0]      y_q, y_d, cy;
  logic                fb_q, fb_d;
  logic                x_ok, y_ok, tries_last;

  // An all-zero state would lock the LFSR, so a zero seed is replaced by SEED.
  always_comb begin
    lfsr_step = lfsr_q[0] ? ((lfsr_q >> 1) ^ TAPS) : (lfsr_q >> 1);
    if (seed_load_i) begin
      lfsr_d = (seed_in_i == '0) ? SEED : seed_in_i;
    end else begin
      lfsr_d = lfsr_step;
    end
  end

  // Candidates are taken from the pre-step LFSR value at the drawing edge.
  assign cx         = lfsr_q[X_W-1:0];
  assign cy         = lfsr_q[Y_W-1:0];
  assign x_ok       = (cx >= XLo) && (cx <= XHi);
  assign y_ok       = (cy >= YLo) && (cy <= YHi);
  assign tries_last = (tries_q == TriesLast);

  always_comb begin
    state_d = state_q;
    tries_d = tries_q;
    x_d     = x_q;
    y_d     = y_q;
    fb_d    = fb_q;
    unique case (state_q)
      StIdle: begin
        if (bus.req && !seed_load_i) begin
          state_d = StDrawX;
          tries_d = '0;
          fb_d    = 1'b0;
        end
      end
      StDrawX: begin
        if (x_ok) begin
          x_d     = cx;
          tries_d = '0;
          state_d = StDrawY;
        end else if (tries_last) begin
          x_d     = XMid;
          fb_d    = 1'b1;
          tries_d = '0;
          state_d = StDrawY;
        end else begin
          tries_d = tries_q + 1'b1;
        end
      end
      StDrawY: begin
        if (y_ok) begin
          y_d     = cy;
          tries_d = '0;
          state_d = StDone;
        end else if (tries_last) begin
          y_d     = YMid;
          fb_d    = 1'b1;
          tries_d = '0;
          state_d = StDone;
        end else begin
          tries_d = tries_q + 1'b1;
        end
      end
      StDone: begin
        if (bus.loc_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      lfsr_q  <= SEED;
      tries_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      fb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      tries_q <= tries_d;
      x_q     <= x_d;
      y_q     <= y_d;
      fb_q    <= fb_d;
    end
  end

  assign bus.busy      = (state_q != StIdle);
  assign bus.loc_valid = (state_q == StDone);
  assign bus.x_loc     = x_q;
  assign bus.y_loc     = y_q;
  assign bus.fallback  = fb_q;

endmodule

// File: tb/tb_lfsr_spawn_gen.sv
// Randomized bench for lfsr_spawn_gen: default-range DUT plus a forced-fallback DUT,
// both checked against a sequence-level model of rejection sampling.
module tb_lfsr_spawn_gen;

  localparam logic [15:0] SEED = 16'hACE1;
  localparam logic [15:0] TAPS = 16'hB400;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        seed_load;
  logic [15:0] seed_in;
  logic        req;
  logic        loc_ready;
  logic        sel;

  logic        o_busy, o_valid, o_fb;
  logic [10:0] o_x;
  logic [9:0]  o_y;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] m_a, m_b;

  always #5 clk = ~clk;

  lfsr_spawn_gen_if #(.X_W(11), .Y_W(10)) bus_a ();
  lfsr_spawn_gen_if #(.X_W(11), .Y_W(10)) bus_b ();

  assign bus_a.req       = req & ~sel;
  assign bus_a.loc_ready = loc_ready & ~sel;
  assign bus_b.req       = req & sel;
  assign bus_b.loc_ready = loc_ready & sel;

  assign o_busy  = sel ? bus_b.busy      : bus_a.busy;
  assign o_valid = sel ? bus_b.loc_valid : bus_a.loc_valid;
  assign o_fb    = sel ? bus_b.fallback  : bus_a.fallback;
  assign o_x     = sel ? bus_b.x_loc     : bus_a.x_loc;
  assign o_y     = sel ? bus_b.y_loc     : bus_a.y_loc;

  lfsr_spawn_gen dut_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .seed_load_i (seed_load),
    .seed_in_i   (seed_in),
    .bus         (bus_a)
  );

  lfsr_spawn_gen #(
    .X_MIN     (2000),
    .X_MAX     (2000),
    .MAX_TRIES (2)
  ) dut_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .seed_load_i (1'b0),
    .seed_in_i   (16'h0000),
    .bus         (bus_b)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  function automatic logic [15:0] step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
  endfunction

  // Walk the LFSR sequence drawing candidates; plat is the number of draw edges needed.
  function automatic void predict(input logic [15:0] l, input bit b,
                                  output int px, output int py, output int pfb,
                                  output int plat);
    int xmin = b ? 2000 : 16;
    int xmax = b ? 2000 : 1263;
    int tries = b ? 2 : 8;
    logic [15:0] s = l;
    bit hit;
    int c;
    plat = 0; pfb = 0; px = 0; py = 0;
    hit = 0;
    for (int k = 0; k < tries; k++) begin
      if (!hit) begin
        s = step(s); plat++; c = int'(s) % 2048;
        if (c >= xmin && c <= xmax) begin hit = 1; px = c; end
      end
    end
    if (!hit) begin px = xmin + (xmax - xmin) / 2; pfb = 1; end
    hit = 0;
    for (int k = 0; k < tries; k++) begin
      if (!hit) begin
        s = step(s); plat++; c = int'(s) % 1024;
        if (c >= 16 && c <= 511) begin hit = 1; py = c; end
      end
    end
    if (!hit) begin py = 16 + (511 - 16) / 2; pfb = 1; end
  endfunction

  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      m_a = SEED; m_b = SEED;
    end else begin
      m_a = seed_load ? ((seed_in == 16'h0) ? SEED : seed_in) : step(m_a);
      m_b = step(m_b);
    end
    #1;
  endtask

  task automatic do_req(input bit b, input bit early, input int hold, input bit pulse);
    int px, py, pfb, plat, lat;
    bit got;
    sel = b;
    predict(b ? m_b : m_a, b, px, py, pfb, plat);
    req = 1'b1; loc_ready = early;
    tick();
    req = 1'b0;
    lat = 0; got = 0;
    while (!got && lat < 20) begin
      tick(); lat++; got = o_valid;
    end
    check("valid_seen", got, 1);
    check("latency", lat, plat);
    check("x_loc", o_x, px);
    check("y_loc", o_y, py);
    check("fallback", o_fb, pfb);
    check("x_range", (o_x >= (b ? 2000 : 16) && o_x <= (b ? 2000 : 1263)), 1);
    check("y_range", (o_y >= 16 && o_y <= 511), 1);
    if (hold > 0) begin
      loc_ready = 1'b0;
      repeat (hold) begin
        req = pulse ? 1'($urandom_range(0, 1)) : 1'b0;
        tick();
      end
      req = 1'b0;
      check("hold_valid", o_valid, 1);
      check("hold_x", o_x, px);
      check("hold_y", o_y, py);
    end
    loc_ready = 1'b1;
    tick();
    loc_ready = 1'b0;
    check("accept_valid", o_valid, 0);
    check("accept_busy", o_busy, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int nfb;
    bit zero_seen;
    rst_n = 1'b0; seed_load = 1'b0; seed_in = '0; req = 1'b0; loc_ready = 1'b0; sel = 1'b0;
    m_a = SEED; m_b = SEED;
    repeat (2) tick();
    check("rst_busy", o_busy, 0);
    check("rst_valid", o_valid, 0);
    check("rst_x", o_x, 0);
    check("rst_y", o_y, 0);
    check("rst_fb", o_fb, 0);
    check("rst_lfsr", dut_a.lfsr_q, 16'hACE1);
    rst_n = 1'b1;
    tick();
    check("first_step", dut_a.lfsr_q, 16'hE270);

    // Known sequence from seed 0xACE1.
    seed_load = 1'b1; seed_in = 16'hACE1;
    tick();
    seed_load = 1'b0; req = 1'b1; loc_ready = 1'b1;
    tick();
    req = 1'b0;
    check("ks_busy", o_busy, 1);
    check("ks_valid_e1", o_valid, 0);
    tick();
    check("ks_valid_e2", o_valid, 0);
    check("ks_x_e2", o_x, 624);
    tick();
    check("ks_valid_e3", o_valid, 1);
    check("ks_x", o_x, 624);
    check("ks_y", o_y, 312);
    check("ks_fb", o_fb, 0);
    tick();
    check("ks_idle_valid", o_valid, 0);
    check("ks_idle_busy", o_busy, 0);
    loc_ready = 1'b0;

    // Asynchronous reset while in DRAW_Y.
    seed_load = 1'b1; seed_in = 16'hACE1;
    tick();
    seed_load = 1'b0; req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    check("mid_busy", o_busy, 1);
    check("mid_x", o_x, 624);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", o_busy, 0);
    check("arst_valid", o_valid, 0);
    check("arst_x", o_x, 0);
    check("arst_y", o_y, 0);
    check("arst_fb", o_fb, 0);
    check("arst_lfsr", dut_a.lfsr_q, 16'hACE1);
    rst_n = 1'b1;
    m_a = SEED; m_b = SEED;
    tick();
    check("arst_step", dut_a.lfsr_q, 16'hE270);

    // Zero seed substitution and no lock-up.
    seed_load = 1'b1; seed_in = 16'h0000;
    tick();
    seed_load = 1'b0;
    check("zero_seed", dut_a.lfsr_q, 16'hACE1);
    zero_seen = 0;
    for (int i = 0; i < 20000; i++) begin
      tick();
      if (dut_a.lfsr_q == 16'h0) zero_seen = 1;
      if (i % 2000 == 1999) check("lfsr_track", dut_a.lfsr_q, m_a);
    end
    check("never_zero", zero_seen, 0);

    // Backpressure: 20 held cycles with req pulses, then exactly one transfer.
    do_req(0, 0, 20, 1);
    loc_ready = 1'b1;
    repeat (3) tick();
    loc_ready = 1'b0;
    check("single_xfer", o_valid, 0);

    // Forced fallback instance.
    nfb = 0;
    for (int i = 0; i < 1000; i++) begin
      do_req(1, 1'($urandom_range(0, 1)), 0, 0);
      if (o_fb) nfb++;
      repeat ($urandom_range(0, 2)) tick();
    end
    check("fb_seen", (nfb > 0), 1);
    sel = 1'b0;

    // Range soak with req/seed_load collisions.
    for (int i = 0; i < 2000; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      if ($urandom_range(0, 7) == 0) begin
        seed_load = 1'b1; req = 1'b1;
        seed_in = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
        tick();
        seed_load = 1'b0; req = 1'b0;
        check("collide_busy", o_busy, 0);
        check("collide_lfsr", dut_a.lfsr_q, m_a);
      end else if ($urandom_range(0, 1) == 0) begin
        do_req(0, 1, 0, 0);
      end else begin
        do_req(0, 0, $urandom_range(0, 4), 1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
